// File: rtl/alu_pkg.sv
// Shared widths, ALU op codes, occupancy states and the buffered-operand record
// for the ALU operand-delivery stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic              use_imm;
    } operand_entry_t;

    // Register 0 is hardwired, so a writeback to it never forwards.
    function automatic logic wb_hit(
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_addr,
        input logic [REG_AW-1:0] addr
    );
        return wb_en && (wb_addr == addr) && (addr != '0);
    endfunction

    // Refresh a held entry with a writeback; an immediate B is never a register.
    function automatic operand_entry_t entry_coherent(
        input operand_entry_t    entry,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        operand_entry_t res;
        res = entry;
        if (wb_hit(wb_en, wb_addr, entry.rs_addr)) begin
            res.a = wb_data;
        end
        if (!entry.use_imm && wb_hit(wb_en, wb_addr, entry.rt_addr)) begin
            res.b = wb_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational capture path: writeback forwarding for A and B plus
// sign/zero extension of the 16-bit immediate.
module operand_fwd_mux
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_AW = alu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    input  logic              use_imm,
    input  logic              imm_zext,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rt_fwd;

    assign imm_ext = {{(DATA_W-16){imm16[15] & ~imm_zext}}, imm16};
    assign rt_fwd  = wb_hit(wb_en, wb_addr, rt_addr) ? wb_data : rt_data;

    assign a = wb_hit(wb_en, wb_addr, rs_addr) ? wb_data : rs_data;
    assign b = use_imm ? imm_ext : rt_fwd;

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the ALU: forwarding/extension on capture,
// then a main+skid buffer whose held entries track later writebacks.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_AW = alu_pkg::REG_AW,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [15:0]       in_imm16,
    input  logic              in_use_imm,
    input  logic              in_imm_zext,
    input  logic [OP_W-1:0]   in_op,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_op
);

    occ_t           occ_reg;
    occ_t           occ_next;
    logic           in_ready_reg;
    logic           in_ready_next;
    operand_entry_t entry_reg [2];
    operand_entry_t entry_upd [2];
    operand_entry_t main_next;
    operand_entry_t skid_next;
    operand_entry_t cap_entry;
    logic [1:0]     entry_valid;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic           accept;
    logic           pop;

    operand_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_mux (
        .rs_addr  (in_rs_addr),
        .rs_data  (in_rs_data),
        .rt_addr  (in_rt_addr),
        .rt_data  (in_rt_data),
        .imm16    (in_imm16),
        .use_imm  (in_use_imm),
        .imm_zext (in_imm_zext),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .a        (cap_a),
        .b        (cap_b)
    );

    always_comb begin
        cap_entry         = '0;
        cap_entry.a       = cap_a;
        cap_entry.b       = cap_b;
        cap_entry.op      = in_op;
        cap_entry.rs_addr = in_rs_addr;
        cap_entry.rt_addr = in_rt_addr;
        cap_entry.use_imm = in_use_imm;
    end

    // Entry 0 is main (drives the ALU), entry 1 is skid.
    assign entry_valid = {occ_reg == OCC_FULL, occ_reg != OCC_EMPTY};

    for (genvar gi = 0; gi < 2; gi++) begin : g_coherence
        assign entry_upd[gi] = entry_valid[gi]
                             ? entry_coherent(entry_reg[gi], wb_en, wb_addr, wb_data)
                             : entry_reg[gi];
    end

    assign accept = in_valid && in_ready_reg;
    assign pop    = out_valid && out_ready;

    always_comb begin
        occ_next  = occ_reg;
        main_next = entry_upd[0];
        skid_next = entry_upd[1];
        if (flush) begin
            occ_next = OCC_EMPTY;
        end else begin
            case (occ_reg)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_next  = OCC_ONE;
                        main_next = cap_entry;
                    end
                end
                OCC_ONE: begin
                    if (accept && !pop) begin
                        occ_next  = OCC_FULL;
                        skid_next = cap_entry;
                    end else if (!accept && pop) begin
                        occ_next = OCC_EMPTY;
                    end else if (accept && pop) begin
                        main_next = cap_entry;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        occ_next  = OCC_ONE;
                        main_next = entry_upd[1];
                    end
                end
                default: begin
                    occ_next = OCC_EMPTY;
                end
            endcase
        end
        in_ready_next = (occ_next != OCC_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_reg      <= OCC_EMPTY;
            in_ready_reg <= 1'b1;
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
        end else begin
            occ_reg      <= occ_next;
            in_ready_reg <= in_ready_next;
            entry_reg[0] <= main_next;
            entry_reg[1] <= skid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (occ_reg != OCC_EMPTY);
    assign out_a     = entry_reg[0].a;
    assign out_b     = entry_reg[0].b;
    assign out_op    = entry_reg[0].op;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding, immediates, stall/skid
// coherence, flush and asynchronous reset, with hand-computed expectations.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs_addr;
    logic [31:0] in_rs_data;
    logic [4:0]  in_rt_addr;
    logic [31:0] in_rt_data;
    logic [15:0] in_imm16;
    logic        in_use_imm;
    logic        in_imm_zext;
    logic [2:0]  in_op;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs_addr  (in_rs_addr),
        .in_rs_data  (in_rs_data),
        .in_rt_addr  (in_rt_addr),
        .in_rt_data  (in_rt_data),
        .in_imm16    (in_imm16),
        .in_use_imm  (in_use_imm),
        .in_imm_zext (in_imm_zext),
        .in_op       (in_op),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op      (out_op)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] rs_a, input logic [31:0] rs_d,
                            input logic [4:0] rt_a, input logic [31:0] rt_d,
                            input logic [2:0] op);
        in_valid    = 1'b1;
        in_rs_addr  = rs_a;
        in_rs_data  = rs_d;
        in_rt_addr  = rt_a;
        in_rt_data  = rt_d;
        in_use_imm  = 1'b0;
        in_imm_zext = 1'b0;
        in_imm16    = 16'h0000;
        in_op       = op;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_a"}, out_a, a);
        chk({tag, "_b"}, out_b, b);
        chk({tag, "_op"}, {29'd0, out_op}, {29'd0, op});
        $display("[TB] %s: a=%h b=%h op=%0d in_ready=%0b", tag, out_a, out_b, out_op, in_ready);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_rs_addr = '0; in_rs_data = '0; in_rt_addr = '0; in_rt_data = '0;
        in_imm16 = '0; in_use_imm = 1'b0; in_imm_zext = 1'b0; in_op = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;

        cycle(); cycle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_out_op", {29'd0, out_op}, 32'd0);
        reset = 1'b0;
        cycle();

        // Basic accept, one-cycle latency
        drive_op(5'd3, 32'h10, 5'd4, 32'h20, 3'b010);
        cycle();
        in_valid = 1'b0;
        chk_out("basic", 32'h10, 32'h20, 3'b010);
        cycle();
        chk("basic_drained", {31'd0, out_valid}, 32'd0);

        // Immediate sign then zero extension, back to back
        drive_op(5'd1, 32'h1, 5'd2, 32'h55, 3'b000);
        in_use_imm = 1'b1; in_imm16 = 16'hFFFE; in_imm_zext = 1'b0;
        cycle();
        chk_out("imm_sext", 32'h1, 32'hFFFFFFFE, 3'b000);
        in_imm_zext = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk_out("imm_zext", 32'h1, 32'h0000FFFE, 3'b000);
        cycle();

        // Same-cycle writeback forwarding, and register 0 exemption
        drive_op(5'd5, 32'h1111, 5'd6, 32'h66, 3'b001);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
        cycle();
        in_valid = 1'b0; wb_en = 1'b0;
        chk_out("fwd_rs5", 32'hDEAD, 32'h66, 3'b001);
        cycle();
        drive_op(5'd0, 32'h2222, 5'd0, 32'h3333, 3'b111);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF;
        cycle();
        in_valid = 1'b0; wb_en = 1'b0;
        chk_out("nofwd_r0", 32'h2222, 32'h3333, 3'b111);
        cycle();

        // Stall: fill main and skid, third op held off
        out_ready = 1'b0;
        drive_op(5'd1, 32'hA1, 5'd2, 32'hB1, 3'b000);
        cycle();
        chk("stall1_in_ready", {31'd0, in_ready}, 32'd1);
        chk_out("stall1", 32'hA1, 32'hB1, 3'b000);
        drive_op(5'd6, 32'hA2, 5'd7, 32'hB2, 3'b001);
        cycle();
        chk("stall2_in_ready", {31'd0, in_ready}, 32'd0);
        chk_out("stall2", 32'hA1, 32'hB1, 3'b000);
        drive_op(5'd8, 32'hA3, 5'd9, 32'hB3, 3'b110);
        cycle();
        chk("stall3_in_ready", {31'd0, in_ready}, 32'd0);
        chk_out("stall3", 32'hA1, 32'hB1, 3'b000);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        cycle();
        wb_en = 1'b0;
        chk_out("skid_wb", 32'hA1, 32'hB1, 3'b000);
        out_ready = 1'b1;
        cycle();
        chk("pop1_in_ready", {31'd0, in_ready}, 32'd1);
        chk_out("pop_skid", 32'hA2, 32'h77, 3'b001);
        cycle();
        in_valid = 1'b0;
        chk_out("pop_third", 32'hA3, 32'hB3, 3'b110);
        cycle();
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // Flush from FULL, then a flush that discards a same-cycle accept
        out_ready = 1'b0;
        drive_op(5'd10, 32'hC1, 5'd11, 32'hD1, 3'b010);
        cycle();
        drive_op(5'd12, 32'hC2, 5'd13, 32'hD2, 3'b010);
        cycle();
        chk("flush_full_in_ready", {31'd0, in_ready}, 32'd0);
        drive_op(5'd14, 32'hE1, 5'd15, 32'hF1, 3'b111);
        flush = 1'b1;
        cycle();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_accept_dropped", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("flush_still_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drive_op(5'd16, 32'h99, 5'd17, 32'h98, 3'b001);
        cycle();
        in_valid = 1'b0;
        chk_out("post_flush", 32'h99, 32'h98, 3'b001);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        cycle();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_a", out_a, 32'd0);
        cycle();
        reset = 1'b0;
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
